lsu_mw: RTL and testbench

//  Memory/writeback stage of the 3-stage pipeline: consumes the registered MW control
//  (reg_wrMW, wr_enMW, rd_enMW, wb_selMW) plus ALU result and store data, runs the

---
 rtl/lsu_mw.sv | 175 +++++++++++++++++
 tb/tb_lsu_mw.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mw.sv
// Memory/writeback stage: runs the data-bus load/store handshake for the MW
// instruction, formats load data and selects the register-file writeback value.
module lsu_mw #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wrMW,
  input  logic        wr_enMW,
  input  logic        rd_enMW,
  input  logic [1:0]  wb_selMW,
  input  logic [2:0]  funct3MW,
  input  logic [31:0] alu_outMW,
  input  logic [31:0] wdataMW,
  input  logic [31:0] pcMW,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        reg_wr_out,
  output logic        mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tmo;
  logic [31:0]      rdata_q;

  logic       access, is_store, is_load, bad, start;
  logic [1:0] size, lane;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      2'b00:   byte_en = 4'b0001 << ln;
      2'b01:   byte_en = ln[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Lane-align the captured word, then sign- or zero-extend by access type.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] ln,
                                           input logic [31:0] raw);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    sh = raw >> {ln, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    sx = '0;
    case (f3)
      3'b000: begin sx = b; load_fmt = sx; end
      3'b001: begin sx = h; load_fmt = sx; end
      3'b100: load_fmt = {24'd0, sh[7:0]};
      3'b101: load_fmt = {16'd0, sh[15:0]};
      default: load_fmt = raw;
    endcase
  endfunction

  assign size     = funct3MW[1:0];
  assign lane     = alu_outMW[1:0];
  assign access   = rd_enMW | wr_enMW;
  assign is_store = wr_enMW;
  assign is_load  = rd_enMW & ~wr_enMW;

  // Stores win when both enables are set, so load-only funct3 checks use is_load.
  assign bad = access & ((size == 2'b11)
                       | ((size == 2'b01) & lane[0])
                       | ((size == 2'b10) & (lane != 2'b00))
                       | (is_load & ((funct3MW == 3'b011) | (funct3MW == 3'b110)
                                     | (funct3MW == 3'b111)))
                       | (is_store & funct3MW[2]));

  assign start = access & ~bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end else if (bad) begin
          mem_err = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dbus_ack || (cnt == CNT_LAST)) state_nxt = DONE;
      end
      DONE: begin
        mem_err   = tmo;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request/attributes are launched from IDLE and held stable through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      rdata_q    <= '0;
      tmo        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {alu_outMW[31:2], 2'b00};
            dbus_be    <= byte_en(size, lane);
            dbus_wdata <= store_data(size, wdataMW);
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            rdata_q  <= dbus_rdata;
            dbus_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            dbus_req <= 1'b0;
            tmo      <= 1'b1;
            rdata_q  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: tmo <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (wb_selMW)
      2'b01:   wb_data = tmo ? 32'd0 : load_fmt(funct3MW, lane, rdata_q);
      2'b10:   wb_data = pcMW + 32'd4;
      default: wb_data = alu_outMW;
    endcase
  end

  assign reg_wr_out = reg_wrMW & ~stall & ~mem_err;

endmodule

// File: tb/tb_lsu_mw.sv
// Directed testbench for lsu_mw: one task per scenario with inline comparisons.
module tb_lsu_mw;

  logic        clk;
  logic        rst;
  logic        reg_wrMW, wr_enMW, rd_enMW;
  logic [1:0]  wb_selMW;
  logic [2:0]  funct3MW;
  logic [31:0] alu_outMW, wdataMW, pcMW;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall, reg_wr_out, mem_err;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  lsu_mw #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .reg_wrMW(reg_wrMW), .wr_enMW(wr_enMW), .rd_enMW(rd_enMW),
    .wb_selMW(wb_selMW), .funct3MW(funct3MW), .alu_outMW(alu_outMW),
    .wdataMW(wdataMW), .pcMW(pcMW),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .stall(stall), .wb_data(wb_data), .reg_wr_out(reg_wr_out), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic rw, input logic we, input logic re,
                           input logic [1:0] sel, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc);
    reg_wrMW = rw; wr_enMW = we; rd_enMW = re; wb_selMW = sel;
    funct3MW = f3; alu_outMW = alu; wdataMW = wd; pcMW = pc;
    #1;
  endtask

  task automatic set_nop();
    set_instr(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
  endtask

  // Steps the current MW instruction to completion, acking on BUSY cycle ack_at (0 = never).
  task automatic run_access(input int ack_at, input logic [31:0] rd,
                            output int n_stall, output int n_busy, output int n_wr,
                            output logic [31:0] wb, output logic err, output logic req_done,
                            output logic [3:0] be, output logic [31:0] wd,
                            output logic we, output logic [31:0] addr, output logic done_ok);
    n_stall = 0; n_busy = 0; n_wr = 0; wb = '0; err = 1'b0; req_done = 1'b0;
    be = '0; wd = '0; we = 1'b0; addr = '0; done_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dbus_req) begin
        n_busy++;
        be = dbus_be; wd = dbus_wdata; we = dbus_we; addr = dbus_addr;
        if (n_busy == ack_at) begin
          dbus_ack = 1'b1;
          dbus_rdata = rd;
        end
      end
      if (stall) n_stall++;
      if (reg_wr_out) n_wr++;
      if (!stall) begin
        wb = wb_data; err = mem_err; req_done = dbus_req; done_ok = 1'b1;
      end
      @(posedge clk); #2; dbus_ack = 1'b0; #1;
      if (done_ok) break;
    end
  endtask

  task automatic test_reset();
    #12;
    tests++; if (dbus_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", dbus_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (dbus_addr !== 32'd0 || dbus_be !== 4'd0 || dbus_wdata !== 32'd0 || dbus_we !== 1'b0) begin
      fails++; $display("FAIL reset_bus got addr=%h be=%b wd=%h we=%b want zeros", dbus_addr, dbus_be, dbus_wdata, dbus_we);
    end
    tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", mem_err); end
    @(posedge clk); #2; rst = 1'b0; #1;
  endtask

  task automatic test_lw_ack3();
    int ns, nb, nw; logic [31:0] wb, wd, ad; logic er, rq, we, ok; logic [3:0] be;
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h100, 32'd0, 32'h40);
    tests++; if (stall !== 1'b1 || dbus_req !== 1'b0) begin
      fails++; $display("FAIL lw_first_cycle got stall=%b req=%b want 1 0", stall, dbus_req);
    end
    tests++; if (reg_wr_out !== 1'b0) begin fails++; $display("FAIL lw_idle_wr got %b want 0", reg_wr_out); end
    run_access(3, 32'hDEADBEEF, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (!ok) begin fails++; $display("FAIL lw_done got timeout want completion"); end
    tests++; if (ns != 4) begin fails++; $display("FAIL lw_stall_cycles got %0d want 4", ns); end
    tests++; if (wb !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_wb got %h want deadbeef", wb); end
    tests++; if (nw != 1) begin fails++; $display("FAIL lw_regwr_cycles got %0d want 1", nw); end
    tests++; if (ad !== 32'h100 || we !== 1'b0 || be !== 4'b1111) begin
      fails++; $display("FAIL lw_bus got addr=%h we=%b be=%b want 100 0 1111", ad, we, be);
    end
    tests++; if (er !== 1'b0 || rq !== 1'b0) begin fails++; $display("FAIL lw_done_flags got err=%b req=%b want 0 0", er, rq); end
  endtask

  task automatic test_store();
    int ns, nb, nw; logic [31:0] wb, wd, ad; logic er, rq, we, ok; logic [3:0] be;
    set_instr(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h203, 32'h000000A5, 32'd0);
    run_access(1, 32'd0, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (be !== 4'b1000 || wd !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL sb_lanes got be=%b wd=%h want 1000 a5a5a5a5", be, wd);
    end
    tests++; if (we !== 1'b1 || ad !== 32'h200) begin fails++; $display("FAIL sb_attr got we=%b addr=%h want 1 200", we, ad); end
    tests++; if (nw != 0 || ns != 2) begin fails++; $display("FAIL sb_timing got wr=%0d stall=%0d want 0 2", nw, ns); end
    set_instr(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h302, 32'h1234ABCD, 32'd0);
    run_access(1, 32'd0, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (be !== 4'b1100 || wd !== 32'hABCDABCD) begin
      fails++; $display("FAIL sh_lanes got be=%b wd=%h want 1100 abcdabcd", be, wd);
    end
  endtask

  task automatic test_load_format();
    int ns, nb, nw; logic [31:0] wb, wd, ad; logic er, rq, we, ok; logic [3:0] be;
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h3, 32'd0, 32'd0);
    run_access(2, 32'h80FFFFFF, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (wb !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext got %h want ffffff80", wb); end
    tests++; if (be !== 4'b1000) begin fails++; $display("FAIL lb_be got %b want 1000", be); end
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b101, 32'h2, 32'd0, 32'd0);
    run_access(1, 32'h80FFFFFF, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (wb !== 32'h000080FF) begin fails++; $display("FAIL lhu_zext got %h want 000080ff", wb); end
    tests++; if (ns != 2) begin fails++; $display("FAIL lhu_min_latency got %0d want 2", ns); end
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b001, 32'h0, 32'd0, 32'd0);
    run_access(1, 32'h0000F00D, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    set_nop();
    tests++; if (wb !== 32'hFFFFF00D) begin fails++; $display("FAIL lh_sext got %h want fffff00d", wb); end
  endtask

  task automatic test_misaligned();
    int ns, nb, nw; logic [31:0] wb, wd, ad; logic er, rq, we, ok; logic [3:0] be;
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h102, 32'd0, 32'd0);
    tests++; if (stall !== 1'b0 || mem_err !== 1'b1 || reg_wr_out !== 1'b0) begin
      fails++; $display("FAIL lw_misaligned got stall=%b err=%b wr=%b want 0 1 0", stall, mem_err, reg_wr_out);
    end
    run_access(1, 32'd0, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    tests++; if (nb != 0 || dbus_req !== 1'b0) begin fails++; $display("FAIL misaligned_bus got busy=%0d req=%b want 0 0", nb, dbus_req); end
    set_instr(1'b0, 1'b1, 1'b0, 2'b00, 3'b100, 32'h100, 32'd0, 32'd0);
    tests++; if (mem_err !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL store_f3_illegal got err=%b stall=%b want 1 0", mem_err, stall);
    end
    set_nop();
  endtask

  task automatic test_timeout();
    int ns, nb, nw; logic [31:0] wb, wd, ad; logic er, rq, we, ok; logic [3:0] be;
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h400, 32'd0, 32'd0);
    run_access(0, 32'd0, ns, nb, nw, wb, er, rq, be, wd, we, ad, ok);
    tests++; if (dbus_req !== 1'b0) begin fails++; $display("FAIL tmo_req_after got %b want 0", dbus_req); end
    set_nop();
    tests++; if (nb != 16 || ns != 17) begin fails++; $display("FAIL tmo_cycles got busy=%0d stall=%0d want 16 17", nb, ns); end
    tests++; if (er !== 1'b1 || wb !== 32'd0 || rq !== 1'b0) begin
      fails++; $display("FAIL tmo_done got err=%b wb=%h req=%b want 1 0 0", er, wb, rq);
    end
    tests++; if (nw != 0) begin fails++; $display("FAIL tmo_regwr got %0d want 0", nw); end
  endtask

  task automatic test_reset_mid_busy();
    set_instr(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h500, 32'd0, 32'd0);
    @(posedge clk); #3;
    @(posedge clk); #3;
    tests++; if (dbus_req !== 1'b1) begin fails++; $display("FAIL rst_busy_pre got req=%b want 1", dbus_req); end
    rst = 1'b1; #1;
    tests++; if (dbus_req !== 1'b0 || dbus_be !== 4'd0) begin
      fails++; $display("FAIL rst_busy_req got req=%b be=%b want 0 0000", dbus_req, dbus_be);
    end
    tests++; if (reg_wr_out !== 1'b0) begin fails++; $display("FAIL rst_busy_wr got %b want 0", reg_wr_out); end
    set_nop();
    @(posedge clk); #2; rst = 1'b0; #1;
    @(posedge clk); #3;
    tests++; if (dbus_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rst_busy_post got req=%b stall=%b want 0 0", dbus_req, stall);
    end
  endtask

  task automatic test_passthrough();
    set_instr(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 32'h1234, 32'd0, 32'hFFFFFFFC);
    tests++; if (wb_data !== 32'd0 || stall !== 1'b0 || reg_wr_out !== 1'b1) begin
      fails++; $display("FAIL jal_wb got wb=%h stall=%b wr=%b want 0 0 1", wb_data, stall, reg_wr_out);
    end
    set_instr(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h55, 32'd0, 32'h0);
    dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
    @(posedge clk); #2; dbus_ack = 1'b0; #1;
    tests++; if (dbus_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL stray_ack got req=%b stall=%b want 0 0", dbus_req, stall);
    end
    tests++; if (wb_data !== 32'h55) begin fails++; $display("FAIL alu_sel00 got %h want 00000055", wb_data); end
    set_instr(1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 32'hCAFE0001, 32'd0, 32'h0);
    tests++; if (wb_data !== 32'hCAFE0001 || reg_wr_out !== 1'b1) begin
      fails++; $display("FAIL alu_sel11 got wb=%h wr=%b want cafe0001 1", wb_data, reg_wr_out);
    end
    set_nop();
  endtask

  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = '0;
    reg_wrMW = 1'b0; wr_enMW = 1'b0; rd_enMW = 1'b0; wb_selMW = '0;
    funct3MW = '0; alu_outMW = '0; wdataMW = '0; pcMW = '0;
    test_reset();
    test_lw_ack3();
    test_store();
    test_load_format();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
